// File: rtl/vga_pkg.sv
// Shared VGA timing constants so the timing, sprite and game stages agree on the same bounds.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-rate strobe: one-clock tick every CLK_DIV system clocks.
module pix_tick_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered syncs and blank aligned to hc/vc.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_tick,
    output logic        frame_end
);

    localparam cnt_t H_END    = cnt_t'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam cnt_t V_END    = cnt_t'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t hc_q, hc_d;
    cnt_t vc_q, vc_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;

    pix_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .tick(pix_tick)
    );

    // Syncs and blank decode the next-state counters so they land on the same edge as hc/vc.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_END) begin
            hc_d = '0;
            vc_d = (vc_q == V_END) ? '0 : vc_q + 1'b1;
        end
        hsync_d = !((hc_d >= HS_START) && (hc_d < HS_END));
        vsync_d = !((vc_d >= VS_START) && (vc_d < VS_END));
        blank_d = (hc_d >= H_VIS) || (vc_d >= V_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
        end else if (pix_tick) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
        end
    end

    assign hc        = hc_q;
    assign vc        = vc_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign frame_end = pix_tick && (hc_q == H_END) && (vc_q == V_END);

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL expose the following parameters (name, default, meaning):
- CLK_DIV, 4: system clocks per pixel (100 MHz to 25 MHz).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: asynchronous active-high reset.
- hc, out, 11: current pixel column, 0..H_TOTAL-1.
- vc, out, 11: current line, 0..V_TOTAL-1.
- blank, out, 1: high outside the visible region; consumed by the sprite stage.
- hsync, out, 1: horizontal sync, active low.
- vsync, out, 1: vertical sync, active low.
- pix_tick, out, 1: one-clk pulse; hc/vc advance on the clock edge that ends this pulse.
- frame_end, out, 1: one-clk pulse coincident with the pix_tick on which hc=H_TOTAL-1 and vc=V_TOTAL-1.

Function
REQ-004 H_TOTAL SHALL be the sum of the four H parameters (800), and V_TOTAL SHALL be the sum of the four V parameters (525).
REQ-005 A divider counter div, width ceil(log2(CLK_DIV)), SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-006 pix_tick SHALL be high exactly when div==CLK_DIV-1, which gives one pulse every CLK_DIV clks.
REQ-007 On a clk edge with pix_tick high, hc SHALL increment; when hc==H_TOTAL-1, hc SHALL wrap to 0 on that edge.
REQ-008 vc SHALL change only on the edge where hc wraps: vc SHALL increment, and when vc==V_TOTAL-1 it SHALL wrap to 0.
REQ-009 hc and vc SHALL hold their values on all edges without pix_tick.
REQ-010 hsync, vsync and blank SHALL be registered, and SHALL be updated on the same edge as hc/vc from the next-state counter values, so that they are always consistent with the hc/vc being output (zero relative latency).
REQ-011 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, that is hc in 656..751.
REQ-012 vsync SHALL be 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, that is vc in 490..491.
REQ-013 blank SHALL be 1 iff hc >= H_ACTIVE or vc >= V_ACTIVE.
REQ-014 frame_end SHALL be combinational, equal to pix_tick AND hc==H_TOTAL-1 AND vc==V_TOTAL-1, and SHALL be high for exactly one clk per frame.
REQ-015 All comparisons SHALL be unsigned, at 11 bits.
REQ-016 hc SHALL never reach H_TOTAL, and vc SHALL never reach V_TOTAL.
REQ-017 Line period SHALL be H_TOTAL*CLK_DIV = 3200 clks, and frame period SHALL be 1,680,000 clks.

Reset
REQ-018 While rst is high, the outputs SHALL hold: div=0, hc=0, vc=0, hsync=1, vsync=1, blank=0, pix_tick=0, frame_end=0.
REQ-019 Reset asserted mid-frame SHALL return all state to the REQ-018 values immediately (asynchronously), without waiting for a clock edge.
REQ-020 After rst deasserts, the first pix_tick SHALL occur on the CLK_DIV-th clk edge.
REQ-021 After reset, hc=0, vc=0 SHALL persist for CLK_DIV clks, and the first pixel SHALL have the full pixel duration.

Structure
REQ-022 H_TOTAL, V_TOTAL, the sync start/end constants and the default timing values SHALL reside in the shared package vga_pkg, so that the sprite and game stages use identical bounds.
REQ-023 The divider SHALL be a sub-module named pix_tick_div (parameter CLK_DIV; ports clk, rst, tick), and the H/V counters SHALL remain inline.

Verification
REQ-024 The bench SHALL cover at least the following directed scenarios (stimulus -> required response):
- Reset release: after reset release, pix_tick asserts at clk edges 4, 8, 12, and hc reads 1 after edge 4.
- Line wrap: at hc=799, vc=10, the next pix_tick gives hc=0, vc=11, and the line period measures 3200 clks.
- hsync window: hsync falls when hc becomes 656 and rises when hc becomes 752, i.e. 96 pixels (384 clks) low.
- Frame wrap: frame_end pulses once at hc=799, vc=524; the next values are hc=0, vc=0, vsync=1, blank=0; frame_end pulses are spaced 1,680,000 clks apart.
- Blank/vsync: blank=1 at (hc=640, vc=0) and at (hc=0, vc=480), blank=0 at (hc=639, vc=479), and vsync=0 only for vc in 490..491.
- Mid-frame reset: rst pulsed at hc=300, vc=200 forces hc=0, vc=0, hsync=1 asynchronously, and the counting sequence then restarts exactly as in the reset-release scenario.
